// File: rtl/boot_image_verifier_if.sv
// rtl/boot_image_verifier_if.sv - word read port between the boot image verifier and image storage
//
// Signals:
//   rd_req   level read request from the verifier
//   rd_addr  word index being requested (stable until the ack cycle)
//   rd_ack   read data valid this cycle
//   rd_data  read data, valid with rd_ack
//   rd_err   read error, qualified by rd_ack
// Modports: master = verifier side, slave = storage side.
interface boot_image_verifier_if;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        rd_err;

  modport master (output rd_req, rd_addr, input rd_ack, rd_data, rd_err);
  modport slave  (input rd_req, rd_addr, output rd_ack, rd_data, rd_err);
endinterface

// File: rtl/boot_image_verifier.sv
// rtl/boot_image_verifier.sv - fetches a boot image and checks its keyed rolling digest
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                begin verification (accepted only in IDLE)
//   img_len, exp_digest  image length in words and expected digest, sampled on start
//   abort                tamper/abort request, forces a fail while busy
//   rd                   word read port (boot_image_verifier_if.master)
//   busy                 high while fetching or checking
//   verify_done          one-cycle result pulse
//   sig_valid            digest matched, held until next accepted start
//   digest               running / final digest
//   err_code             result code (only with BOOT_VERIFY_ERRCODE_EN defined)
//
// Optional feature macro: BOOT_VERIFY_ERRCODE_EN adds err_code[2:0]
//   0 pass, 1 bad length, 2 read error, 3 ack timeout, 4 digest mismatch, 5 abort.
module boot_image_verifier #(
  parameter logic [31:0] KEY         = 32'hA5C3_5A3C,
  parameter logic [15:0] MAX_LEN     = 16'd4096,
  parameter logic [15:0] ACK_TIMEOUT = 16'd1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [15:0]                  img_len,
  input  logic [31:0]                  exp_digest,
  input  logic                         abort,
  boot_image_verifier_if.master        rd,
  output logic                         busy,
  output logic                         verify_done,
  output logic                         sig_valid,
  output logic [31:0]                  digest
`ifdef BOOT_VERIFY_ERRCODE_EN
  ,
  output logic [2:0]                   err_code
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] len_q, len_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] digest_q, digest_d;
  logic        sig_q, sig_d;

`ifdef BOOT_VERIFY_ERRCODE_EN
  localparam logic [2:0] ERR_PASS     = 3'd0;
  localparam logic [2:0] ERR_LEN      = 3'd1;
  localparam logic [2:0] ERR_RD       = 3'd2;
  localparam logic [2:0] ERR_TMO      = 3'd3;
  localparam logic [2:0] ERR_MISMATCH = 3'd4;
  localparam logic [2:0] ERR_ABORT    = 3'd5;
  logic [2:0] err_q, err_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      index_q  <= 16'd0;
      tmo_q    <= 16'd0;
      len_q    <= 16'd0;
      exp_q    <= 32'd0;
      digest_q <= KEY;
      sig_q    <= 1'b0;
`ifdef BOOT_VERIFY_ERRCODE_EN
      err_q    <= 3'd0;
`endif
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      tmo_q    <= tmo_d;
      len_q    <= len_d;
      exp_q    <= exp_d;
      digest_q <= digest_d;
      sig_q    <= sig_d;
`ifdef BOOT_VERIFY_ERRCODE_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    tmo_d    = tmo_q;
    len_d    = len_q;
    exp_d    = exp_q;
    digest_d = digest_q;
    sig_d    = sig_q;
`ifdef BOOT_VERIFY_ERRCODE_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = img_len;
          exp_d    = exp_digest;
          digest_d = KEY;
          index_d  = 16'd0;
          tmo_d    = 16'd0;
          sig_d    = 1'b0;
`ifdef BOOT_VERIFY_ERRCODE_EN
          err_d    = ERR_PASS;
`endif
          if (img_len == 16'd0 || img_len > MAX_LEN) begin
            state_d = DONE;
`ifdef BOOT_VERIFY_ERRCODE_EN
            err_d   = ERR_LEN;
`endif
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        // abort wins over a same-cycle ack: the word is not folded in
        if (abort) begin
          state_d = DONE;
`ifdef BOOT_VERIFY_ERRCODE_EN
          err_d   = ERR_ABORT;
`endif
        end else if (rd.rd_ack) begin
          if (rd.rd_err) begin
            state_d = DONE;
`ifdef BOOT_VERIFY_ERRCODE_EN
            err_d   = ERR_RD;
`endif
          end else begin
            digest_d = {digest_q[26:0], digest_q[31:27]} + (rd.rd_data ^ KEY);
            index_d  = index_q + 16'd1;
            tmo_d    = 16'd0;
            if (index_q == len_q - 16'd1) begin
              state_d = CHECK;
            end
          end
        end else if (tmo_q == ACK_TIMEOUT - 16'd1) begin
          // this was the last allowed wait cycle for the outstanding read
          state_d = DONE;
`ifdef BOOT_VERIFY_ERRCODE_EN
          err_d   = ERR_TMO;
`endif
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      CHECK: begin
        state_d = DONE;
        if (abort) begin
`ifdef BOOT_VERIFY_ERRCODE_EN
          err_d = ERR_ABORT;
`endif
        end else if (digest_q == exp_q) begin
          sig_d = 1'b1;
`ifdef BOOT_VERIFY_ERRCODE_EN
          err_d = ERR_PASS;
`endif
        end else begin
`ifdef BOOT_VERIFY_ERRCODE_EN
          err_d = ERR_MISMATCH;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rd.rd_req   = (state_q == FETCH);
  assign rd.rd_addr  = index_q;
  assign busy        = (state_q == FETCH) || (state_q == CHECK);
  assign verify_done = (state_q == DONE);
  assign sig_valid   = sig_q;
  assign digest      = digest_q;
`ifdef BOOT_VERIFY_ERRCODE_EN
  assign err_code    = err_q;
`endif

endmodule

// File: tb/tb_boot_image_verifier.sv
// tb/tb_boot_image_verifier.sv - self-checking bench for boot_image_verifier
module tb_boot_image_verifier;
  localparam logic [31:0] KEY    = 32'hA5C3_5A3C;
  localparam int          ACK_TO = 1024;
  localparam int          BUDGET = 6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] img_len = 16'd0;
  logic [31:0] exp_digest = 32'd0;
  logic        abort = 1'b0;
  logic        busy, verify_done, sig_valid;
  logic [31:0] digest;
`ifdef BOOT_VERIFY_ERRCODE_EN
  logic [2:0]  err_code;
  logic [2:0]  r_err;
`endif

  boot_image_verifier_if rd_bus ();

  boot_image_verifier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .img_len     (img_len),
    .exp_digest  (exp_digest),
    .abort       (abort),
    .rd          (rd_bus.master),
    .busy        (busy),
    .verify_done (verify_done),
    .sig_valid   (sig_valid),
    .digest      (digest)
`ifdef BOOT_VERIFY_ERRCODE_EN
    ,
    .err_code    (err_code)
`endif
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] img [0:4095];

  // per-run observations
  int          r_done_iter, r_last_ack_iter, r_pulses, r_req_cycles, r_addr_bad;
  int          r_stall_cycles, r_req_after_abort;
  logic        r_sig_done, r_sig_early, r_busy_after, r_sig_after;
  logic [31:0] r_digest_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference digest: seed with KEY, then for each word d = rotl(d,5) + (w ^ KEY)
  function automatic logic [31:0] ref_digest(input int n);
    logic [31:0] d;
    d = KEY;
    for (int k = 0; k < n; k++) d = ((d << 5) | (d >> 27)) + (img[k] ^ KEY);
    return d;
  endfunction

  task automatic fill_img(input int n);
    for (int k = 0; k < n; k++) img[k] = $urandom;
  endtask

  // Drives one verification and plays the storage side. Storage stalls forever
  // on stall_w, errors on err_w, and abort is raised with the ack on abort_w.
  // stop_acks > 0 returns right after that many acks have been taken.
  task automatic run(input int len, input logic [31:0] exp, input int stall_w,
                     input int err_w, input int abort_w, input bit gaps,
                     input int stop_acks, input int busy_start_iter);
    int  idx;
    int  acks;
    bit  aborted;
    idx = 0; acks = 0; aborted = 1'b0;
    r_done_iter = -1; r_last_ack_iter = -100; r_pulses = 0; r_req_cycles = 0;
    r_addr_bad = 0; r_stall_cycles = 0; r_req_after_abort = 0;
    r_sig_done = 1'bx; r_sig_early = 1'bx; r_busy_after = 1'bx; r_sig_after = 1'bx;
    r_digest_done = 32'hx;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (i == 1) r_sig_early = sig_valid;
      if (verify_done) begin
        r_pulses++;
        if (r_done_iter < 0) begin
          r_done_iter   = i;
          r_sig_done    = sig_valid;
          r_digest_done = digest;
`ifdef BOOT_VERIFY_ERRCODE_EN
          r_err         = err_code;
`endif
        end
      end
      if (r_done_iter >= 0 && i == r_done_iter + 3) begin
        r_busy_after = busy;
        r_sig_after  = sig_valid;
        break;
      end
      if (rd_bus.rd_req) begin
        r_req_cycles++;
        if (aborted) r_req_after_abort++;
        if (rd_bus.rd_addr !== idx[15:0]) r_addr_bad++;
        if (idx == stall_w) r_stall_cycles++;
      end
      start      = (i == 0) || (i == busy_start_iter);
      img_len    = (i == 0) ? len[15:0] : 16'd1;
      exp_digest = (i == 0) ? exp : 32'd0;
      abort      = 1'b0;
      rd_bus.rd_ack  = 1'b0;
      rd_bus.rd_err  = 1'b0;
      rd_bus.rd_data = $urandom;
      if (rd_bus.rd_req && !aborted && idx != stall_w && (!gaps || $urandom_range(0, 2) != 0)) begin
        rd_bus.rd_ack   = 1'b1;
        r_last_ack_iter = i;
        acks++;
        if (idx == err_w) begin
          rd_bus.rd_err = 1'b1;
        end else if (idx == abort_w) begin
          abort   = 1'b1;
          aborted = 1'b1;
        end else begin
          rd_bus.rd_data = img[idx];
          idx++;
        end
      end
      if (stop_acks > 0 && acks == stop_acks) begin
        @(posedge clk);
        #1;
        break;
      end
    end
    start = 1'b0; abort = 1'b0;
    rd_bus.rd_ack = 1'b0; rd_bus.rd_err = 1'b0;
  endtask

  task automatic chk_result(input string tag, input logic exp_sig, input logic [2:0] exp_code);
    chk({tag, "_done_seen"}, 32'(r_done_iter >= 0), 32'd1);
    chk({tag, "_one_pulse"}, 32'(r_pulses), 32'd1);
    chk({tag, "_sig"}, {31'd0, r_sig_done}, {31'd0, exp_sig});
    chk({tag, "_sig_held"}, {31'd0, r_sig_after}, {31'd0, exp_sig});
    chk({tag, "_idle_after"}, {31'd0, r_busy_after}, 32'd0);
    chk({tag, "_sig_clr_on_start"}, {31'd0, r_sig_early}, 32'd0);
`ifdef BOOT_VERIFY_ERRCODE_EN
    chk({tag, "_err_code"}, {29'd0, r_err}, {29'd0, exp_code});
`else
    if (exp_code > 3'd5) chk({tag, "_code_range"}, {29'd0, exp_code}, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] m;
    int          n;
    bit          want_pass;

    rd_bus.rd_ack = 1'b0; rd_bus.rd_err = 1'b0; rd_bus.rd_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", {31'd0, rd_bus.rd_req}, 32'd0);
    chk("rst_rd_addr", {16'd0, rd_bus.rd_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_verify_done", {31'd0, verify_done}, 32'd0);
    chk("rst_sig_valid", {31'd0, sig_valid}, 32'd0);
    chk("rst_digest", digest, KEY);
    rst_n = 1'b1;

    // single zero word: known digest, pass
    img[0] = 32'd0;
    run(1, 32'h5E2EA1D0, -1, -1, -1, 1'b0, 0, -1);
    chk_result("len1_pass", 1'b1, 3'd0);
    chk("len1_digest", r_digest_done, 32'h5E2EA1D0);
    chk("len1_latency", 32'(r_done_iter - r_last_ack_iter), 32'd2);

    // same image, off-by-one expected value
    run(1, 32'h5E2EA1D1, -1, -1, -1, 1'b0, 0, -1);
    chk_result("len1_mismatch", 1'b0, 3'd4);
    chk("len1_mm_digest", r_digest_done, 32'h5E2EA1D0);

    // illegal lengths
    run(0, 32'd0, -1, -1, -1, 1'b0, 0, -1);
    chk_result("len0", 1'b0, 3'd1);
    chk("len0_latency", 32'(r_done_iter), 32'd1);
    chk("len0_no_req", 32'(r_req_cycles), 32'd0);
    run(4097, 32'd0, -1, -1, -1, 1'b0, 0, -1);
    chk_result("len4097", 1'b0, 3'd1);
    chk("len4097_latency", 32'(r_done_iter), 32'd1);
    chk("len4097_no_req", 32'(r_req_cycles), 32'd0);

    // ack timeout on word 3
    fill_img(8);
    run(8, ref_digest(8), 3, -1, -1, 1'b1, 0, -1);
    chk_result("timeout", 1'b0, 3'd3);
    chk("timeout_wait_cycles", 32'(r_stall_cycles), 32'(ACK_TO));
    chk("timeout_addr", 32'(r_addr_bad), 32'd0);

    // read error on word 3: digest covers only words 0..2
    fill_img(8);
    run(8, ref_digest(8), -1, 3, -1, 1'b1, 0, -1);
    chk_result("rd_err", 1'b0, 3'd2);
    chk("rd_err_digest", r_digest_done, ref_digest(3));

    // abort with ack on word 5, plus a start while busy that must be ignored
    fill_img(16);
    run(16, ref_digest(16), -1, -1, 5, 1'b0, 0, 4);
    chk_result("abort", 1'b0, 3'd5);
    chk("abort_latency", 32'(r_done_iter - r_last_ack_iter), 32'd1);
    chk("abort_no_req_after", 32'(r_req_after_abort), 32'd0);
    chk("abort_addr_seq", 32'(r_addr_bad), 32'd0);

    // back-to-back, one word per cycle
    fill_img(4);
    run(4, ref_digest(4), -1, -1, -1, 1'b0, 0, -1);
    chk_result("b2b", 1'b1, 3'd0);
    chk("b2b_req_cycles", 32'(r_req_cycles), 32'd4);
    chk("b2b_addr_seq", 32'(r_addr_bad), 32'd0);
    chk("b2b_digest", r_digest_done, ref_digest(4));

    // largest legal image
    fill_img(4096);
    run(4096, ref_digest(4096), -1, -1, -1, 1'b0, 0, -1);
    chk_result("len_max", 1'b1, 3'd0);
    chk("len_max_digest", r_digest_done, ref_digest(4096));

    // random lengths with gapped acks, random pass/fail
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 40);
      fill_img(n);
      want_pass = 1'($urandom_range(0, 1));
      m = ref_digest(n);
      run(n, want_pass ? m : (m ^ (32'd1 << $urandom_range(0, 31))), -1, -1, -1, 1'b1, 0, -1);
      chk_result("rand", want_pass, want_pass ? 3'd0 : 3'd4);
      chk("rand_digest", r_digest_done, m);
      chk("rand_addr_seq", 32'(r_addr_bad), 32'd0);
    end

    // asynchronous reset in the middle of a fetch
    fill_img(16);
    run(16, ref_digest(16), -1, -1, -1, 1'b0, 6, -1);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_req", {31'd0, rd_bus.rd_req}, 32'd0);
    chk("mid_rst_rd_addr", {16'd0, rd_bus.rd_addr}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_verify_done", {31'd0, verify_done}, 32'd0);
    chk("mid_rst_sig_valid", {31'd0, sig_valid}, 32'd0);
    chk("mid_rst_digest", digest, KEY);
    @(negedge clk);
    rst_n = 1'b1;
    fill_img(5);
    run(5, ref_digest(5), -1, -1, -1, 1'b1, 0, -1);
    chk_result("post_rst", 1'b1, 3'd0);
    chk("post_rst_digest", r_digest_done, ref_digest(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/boot_image_verifier.md
Name: boot_image_verifier

Overview:
- Upstream stage of the secure boot release controller. On start, it fetches the boot image word by word over a req/ack read port and folds each word into a keyed 32-bit rolling digest.
- It compares the final digest against the expected value and reports the result as a one-cycle verify_done pulse plus a held sig_valid. These feed the controller's verify_done/sig_valid inputs directly.

Parameters:
- KEY, 32'hA5C3_5A3C, digest seed and per-word whitening key.
- MAX_LEN, 16'd4096, largest accepted image length in words.
- ACK_TIMEOUT, 16'd1024, maximum cycles a single read may wait for rd_ack.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  begin verification; accepted only in IDLE
- img_len  input  16  image length in words; sampled on accepted start
- exp_digest  input  32  expected digest; sampled on accepted start
- abort  input  1  tamper/abort request; forces a fail
- rd_req  output  1  read request, level
- rd_addr  output  16  word index being read
- rd_ack  input  1  read data valid this cycle
- rd_data  input  32  read data; sampled when rd_ack=1
- rd_err  input  1  read error; qualified by rd_ack
- busy  output  1  high in FETCH or CHECK
- verify_done  output  1  one-cycle result pulse
- sig_valid  output  1  digest matched; held until next accepted start
- digest  output  32  current/final digest

Behaviour:
- Reset values: rd_req=0, rd_addr=0, busy=0, verify_done=0, sig_valid=0, digest=KEY. State is IDLE. Internal index, timeout counter and latched length/expected value are all 0.
- States: IDLE, FETCH, CHECK, DONE.
- IDLE, start=1: latch img_len and exp_digest, set digest=KEY, index=0, and clear sig_valid.
  - If img_len==0 or img_len>MAX_LEN, go to DONE with fail.
  - Otherwise go to FETCH.
  - start is ignored in every other state.
- FETCH: rd_req=1 and rd_addr=index. rd_addr stays stable until the ack cycle.
- On rd_ack=1 with rd_err=0:
  - digest <= rotl(digest,5) + (rd_data ^ KEY), modulo 2^32.
  - index increments and the timeout counter clears.
  - If this was word img_len-1, go to CHECK (rd_req=0 next cycle). Otherwise stay in FETCH with the next address next cycle, so back-to-back acks give 1 word/cycle.
- On rd_ack=1 with rd_err=1: go to DONE with fail; digest is not updated.
- Timeout: the counter counts FETCH cycles without an ack. If no ack arrives within ACK_TIMEOUT cycles of a request, go to DONE with fail and drop rd_req.
- CHECK, one cycle: pass if digest==exp_digest, otherwise fail. Go to DONE.
- Entering DONE: verify_done=1 for exactly one cycle and sig_valid=pass; sig_valid is never 1 on a fail. DONE returns to IDLE the following cycle.
- Latency: verify_done rises 2 cycles after the final ack.
- abort=1 in FETCH or CHECK: go to DONE with fail, overriding any same-cycle ack or match. abort is ignored in IDLE and DONE.
- busy = (state==FETCH || state==CHECK).
- digest output holds its final value after DONE until the next accepted start.
- Asynchronous reset mid-fetch returns every output to its reset value immediately. No partial result is retained.

Optional Feature:
- Macro BOOT_VERIFY_ERRCODE_EN.
- Defined: adds output err_code[2:0]. It is updated on entering DONE and held until the next accepted start.
  - Codes: 0 pass, 1 bad length, 2 read error, 3 ack timeout, 4 digest mismatch, 5 abort.
  - Reset value 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- img_len=1, exp_digest=32'h5E2EA1D0; ack addr 0 with rd_data=0 → digest=32'h5E2EA1D0, verify_done pulse 2 cycles after ack, sig_valid=1 (err_code=0).
- Same image with exp_digest=32'h5E2EA1D1 → verify_done pulse with sig_valid=0 (err_code=4).
- img_len=0, then img_len=4097 → verify_done 1 cycle after start, sig_valid=0, rd_req never asserted (err_code=1).
- img_len=8, acks stalled on word 3 → rd_req drops after ACK_TIMEOUT=1024 cycles, fail (err_code=3). Repeat with rd_err on word 3 → fail (err_code=2).
- img_len=16, abort pulsed during word 5 together with an ack → fail on the next cycle, no further rd_req (err_code=5). A start issued while busy is ignored.
- img_len=4, back-to-back acks → rd_addr 0,1,2,3 on consecutive cycles. rst_n asserted mid-run → all outputs at reset values, then a fresh start verifies correctly.
